// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC bus transaction engine.
//   state_t     : transaction phases, in the order they are walked
//   DEF_*_CYC   : default phase lengths in clock cycles
//   STROBE_IDLE : {ChipSelect, Read, Write} with every strobe inactive
//   bus_ctl()   : bus control levels that belong to a given phase
package rtc_bus_pkg;

  typedef enum logic [3:0] {
    IDLE,
    A_SETUP,
    A_PULSE,
    A_HOLD,
    A_GAP,
    D_SETUP,
    D_PULSE,
    D_HOLD,
    D_GAP
  } state_t;

  localparam int DEF_SETUP_CYC = 2;
  localparam int DEF_PULSE_CYC = 10;
  localparam int DEF_HOLD_CYC  = 2;
  localparam int DEF_GAP_CYC   = 4;

  // Bit order is {ChipSelect, Read, Write}; all strobes are active low.
  localparam logic [2:0] STROBE_IDLE = 3'b111;

  typedef struct packed {
    logic [2:0] strobes;  // {cs_n, rd_n, wr_n}
    logic       aod;      // 0 = address phase, 1 = data phase
    logic       oe;       // drive the shared bus
  } bus_ctl_t;

  // The address is always latched by the Write strobe, even for reads.
  // In the data phase the bus is only driven for writes.
  function automatic bus_ctl_t bus_ctl(state_t s, logic is_wr);
    bus_ctl_t c;
    c.strobes = STROBE_IDLE;
    c.aod     = 1'b1;
    c.oe      = 1'b0;
    case (s)
      A_SETUP, A_HOLD: begin
        c.strobes = 3'b011;
        c.aod     = 1'b0;
        c.oe      = 1'b1;
      end
      A_PULSE: begin
        c.strobes = 3'b010;
        c.aod     = 1'b0;
        c.oe      = 1'b1;
      end
      D_SETUP, D_HOLD: begin
        c.strobes = 3'b011;
        c.oe      = is_wr;
      end
      D_PULSE: begin
        c.strobes = is_wr ? 3'b010 : 3'b001;
        c.oe      = is_wr;
      end
      default: ;  // IDLE and both gaps: chip deselected, bus released
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rtc_bus_ctrl_timer.sv
// rtc_phase_timer: loadable down-counter that times every bus phase.
//   clk      : system clock
//   Reset    : synchronous active-high reset (count cleared)
//   load     : load load_val this cycle (phase entry)
//   load_val : phase length minus one
//   expired  : count has reached zero (last cycle of the phase)
module rtc_phase_timer
  import rtc_bus_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count_reg;

  // Counter parks at zero, so a phase of length one is expired on entry.
  always_ff @(posedge clk) begin
    if (Reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: one-at-a-time read/write engine for the RTC chip's
// multiplexed address/data bus.
//   clk, Reset             : clock, synchronous active-high reset
//   req, wr, addr, wdata   : request and its parameters (captured in IDLE)
//   busy, done, rdata      : status, completion pulse, last read value
//   ChipSelect/Read/Write  : active-low chip strobes
//   AoD                    : 0 = address phase, 1 = data phase
//   ad_out, ad_oe, ad_in   : bidirectional pad split into drive/enable/sense
// Every output comes straight from a flop; output levels are derived from
// the next state so they line up with the state register.
module rtc_bus_ctrl
  import rtc_bus_pkg::*;
#(
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int GAP_CYC   = DEF_GAP_CYC
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       req,
  input  logic       wr,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       ChipSelect,
  output logic       Read,
  output logic       Write,
  output logic       AoD,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

  localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_HG  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int MAX_CYC = (MAX_SP > MAX_HG) ? MAX_SP : MAX_HG;
  localparam int TW      = $clog2(MAX_CYC) + 1;

  state_t         state_reg, state_next;
  logic           wr_reg;
  logic [7:0]     wdata_reg;
  logic           tmr_load, tmr_expired;
  logic [TW-1:0]  tmr_val;
  bus_ctl_t       ctl_next;

  function automatic logic [TW-1:0] phase_len(state_t s);
    case (s)
      A_SETUP, D_SETUP: phase_len = TW'(SETUP_CYC - 1);
      A_PULSE, D_PULSE: phase_len = TW'(PULSE_CYC - 1);
      A_HOLD,  D_HOLD:  phase_len = TW'(HOLD_CYC - 1);
      A_GAP,   D_GAP:   phase_len = TW'(GAP_CYC - 1);
      default:          phase_len = '0;
    endcase
  endfunction

  rtc_phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .Reset    (Reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req)         state_next = A_SETUP;
      A_SETUP: if (tmr_expired) state_next = A_PULSE;
      A_PULSE: if (tmr_expired) state_next = A_HOLD;
      A_HOLD:  if (tmr_expired) state_next = A_GAP;
      A_GAP:   if (tmr_expired) state_next = D_SETUP;
      D_SETUP: if (tmr_expired) state_next = D_PULSE;
      D_PULSE: if (tmr_expired) state_next = D_HOLD;
      D_HOLD:  if (tmr_expired) state_next = D_GAP;
      D_GAP:   if (tmr_expired) state_next = IDLE;
      default:                  state_next = IDLE;
    endcase

    // No state loops onto itself, so any change is a phase entry.
    tmr_load = (state_next != state_reg) && (state_next != IDLE);
    tmr_val  = phase_len(state_next);

    // wr_reg is stale on the acceptance edge, but the address phase
    // levels do not depend on it.
    ctl_next = bus_ctl(state_next, wr_reg);
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_reg  <= IDLE;
      wr_reg     <= 1'b0;
      wdata_reg  <= '0;
      ChipSelect <= STROBE_IDLE[2];
      Read       <= STROBE_IDLE[1];
      Write      <= STROBE_IDLE[0];
      AoD        <= 1'b1;
      ad_oe      <= 1'b0;
      ad_out     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rdata      <= '0;
    end else begin
      state_reg                 <= state_next;
      {ChipSelect, Read, Write} <= ctl_next.strobes;
      AoD                       <= ctl_next.aod;
      ad_oe                     <= ctl_next.oe;
      busy                      <= (state_next != IDLE);
      done                      <= (state_reg == D_GAP) && (state_next == IDLE);

      // Bus value only moves together with CS falling, never under a strobe.
      if (state_reg == IDLE && req) begin
        wr_reg    <= wr;
        wdata_reg <= wdata;
        ad_out    <= addr;
      end
      if (state_reg == A_GAP && state_next == D_SETUP) begin
        ad_out <= wdata_reg;
      end

      // Sample on the edge where Read rises: the chip has had the whole
      // pulse to drive the bus.
      if (state_reg == D_PULSE && state_next == D_HOLD && !wr_reg) begin
        rdata <= ad_in;
      end
    end
  end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Bench for rtc_bus_ctrl: one instance with default timing and one with all
// phase lengths at 1, fed the same requests. A cycle-index model predicts
// every output of both instances each cycle; literal checks pin key numbers.
module tb_rtc_bus_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, req, wr;
  logic [7:0] addr, wdata, bus_val;

  logic [1:0] busy_o, done_o, cs_o, rd_o, wr_o, aod_o, oe_o;
  logic [7:0] rdata_o [2];
  logic [7:0] ad_out_o [2];
  logic [7:0] ad_in_o [2];

  // Chip model: drives bus_val while Read is low, otherwise a filler value.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bus
    assign ad_in_o[gi] = rd_o[gi] ? 8'hA5 : bus_val;
  end

  rtc_bus_ctrl dut0 (
    .clk(clk), .Reset(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .busy(busy_o[0]), .done(done_o[0]), .rdata(rdata_o[0]),
    .ChipSelect(cs_o[0]), .Read(rd_o[0]), .Write(wr_o[0]), .AoD(aod_o[0]),
    .ad_out(ad_out_o[0]), .ad_oe(oe_o[0]), .ad_in(ad_in_o[0])
  );

  rtc_bus_ctrl #(.SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1), .GAP_CYC(1)) dut1 (
    .clk(clk), .Reset(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .busy(busy_o[1]), .done(done_o[1]), .rdata(rdata_o[1]),
    .ChipSelect(cs_o[1]), .Read(rd_o[1]), .Write(wr_o[1]), .AoD(aod_o[1]),
    .ad_out(ad_out_o[1]), .ad_oe(oe_o[1]), .ad_in(ad_in_o[1])
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit armed = 0;

  // Model: t = cycle index inside a transaction (0 = idle, 1..N busy).
  int         t [2];
  logic       m_wr [2];
  logic       m_done [2];
  logic [7:0] m_addr [2];
  logic [7:0] m_wdata [2];
  logic [7:0] m_rdata [2];

  // Event counters for literal checks.
  int busy_cnt [2], done_cnt [2], done_cyc [2];
  int wla [2], wld [2], rlow [2], data_oe [2];

  function automatic int ps(int id); return id == 0 ? 2 : 1;  endfunction
  function automatic int pp(int id); return id == 0 ? 10 : 1; endfunction
  function automatic int ph(int id); return id == 0 ? 2 : 1;  endfunction
  function automatic int pg(int id); return id == 0 ? 4 : 1;  endfunction

  task automatic step(input int id);
    int hf;
    hf = ps(id) + pp(id) + ph(id) + pg(id);
    if (rst) begin
      t[id]       = 0;
      m_done[id]  = 1'b0;
      m_rdata[id] = 8'h00;
      m_wr[id]    = 1'b0;
    end else begin
      m_done[id] = (t[id] == 2 * hf);
      if (t[id] == hf + ps(id) + pp(id) && !m_wr[id]) m_rdata[id] = bus_val;
      if (t[id] == 2 * hf) begin
        t[id] = 0;
      end else if (t[id] == 0) begin
        if (req) begin
          t[id]       = 1;
          m_wr[id]    = wr;
          m_addr[id]  = addr;
          m_wdata[id] = wdata;
        end
      end else begin
        t[id] = t[id] + 1;
      end
    end
  endtask

  task automatic check(input int id);
    int s, p, h, g, hf, u;
    logic dph, pulse, gap;
    logic e_cs, e_rd, e_wr, e_aod, e_oe;
    logic [7:0] e_ad;
    logic [14:0] exp_v, act_v;
    s = ps(id); p = pp(id); h = ph(id); g = pg(id);
    hf = s + p + h + g;
    if (t[id] == 0) begin
      e_cs = 1; e_rd = 1; e_wr = 1; e_aod = 1; e_oe = 0; dph = 0;
    end else begin
      dph   = (t[id] > hf);
      u     = dph ? t[id] - hf : t[id];
      pulse = (u > s) && (u <= s + p);
      gap   = (u > s + p + h);
      e_cs  = gap;
      e_aod = dph | gap;
      e_wr  = !(pulse && (!dph || m_wr[id]));
      e_rd  = !(pulse && dph && !m_wr[id]);
      e_oe  = !gap && (!dph || m_wr[id]);
    end
    exp_v = {t[id] != 0, m_done[id], e_cs, e_rd, e_wr, e_aod, e_oe, m_rdata[id]};
    act_v = {busy_o[id], done_o[id], cs_o[id], rd_o[id], wr_o[id], aod_o[id],
             oe_o[id], rdata_o[id]};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL cyc=%0d dut%0d outputs{busy,done,cs,rd,wr,aod,oe,rdata}: got %b required %b",
               cyc, id, act_v, exp_v);
    end
    if (e_oe) begin
      e_ad = dph ? m_wdata[id] : m_addr[id];
      n_cmp++;
      if (ad_out_o[id] !== e_ad) begin
        n_bad++;
        $display("FAIL cyc=%0d dut%0d ad_out: got %h required %h", cyc, id, ad_out_o[id], e_ad);
      end
    end
    if (busy_o[id]) busy_cnt[id]++;
    if (done_o[id]) begin done_cnt[id]++; done_cyc[id] = cyc; end
    if (!wr_o[id] && !aod_o[id]) wla[id]++;
    if (!wr_o[id] && aod_o[id]) wld[id]++;
    if (!rd_o[id]) rlow[id]++;
    if (aod_o[id] && !cs_o[id] && oe_o[id]) data_oe[id]++;
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    step(0);
    step(1);
    if (rst) armed = 1;
    #1;
    if (armed) begin
      check(0);
      check(1);
    end
  end

  task automatic clear_ctrs();
    for (int i = 0; i < 2; i++) begin
      busy_cnt[i] = 0; done_cnt[i] = 0; done_cyc[i] = -1;
      wla[i] = 0; wld[i] = 0; rlow[i] = 0; data_oe[i] = 0;
    end
  endtask

  task automatic lit(input string name, input int got, input int req_v);
    n_cmp++;
    if (got != req_v) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, got, req_v);
    end
  endtask

  // Issues a one-cycle request; k is the cycle whose closing edge samples it.
  task automatic start(input logic w, input logic [7:0] a, input logic [7:0] d,
                       output int k);
    @(negedge clk);
    wr = w; addr = a; wdata = d; req = 1'b1;
    k = cyc;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_done(input int id, input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done_o[id] === 1'b1) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s: done not seen within 200 cycles (required a done pulse)", name);
    end
  endtask

  initial begin
    int k;
    bit seen;
    rst = 1'b1; req = 1'b0; wr = 1'b0; addr = 8'h00; wdata = 8'h00; bus_val = 8'h00;
    clear_ctrs();
    repeat (3) @(negedge clk);
    lit("reset_busy", busy_o[0], 0);
    lit("reset_cs", cs_o[0], 1);
    lit("reset_rdata", rdata_o[0], 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Write 0x21 <- 0x45
    $display("txn: write addr=21 wdata=45");
    clear_ctrs();
    start(1'b1, 8'h21, 8'h45, k);
    wait_done(0, "write_done");
    lit("write_done_cycle", done_cyc[0], k + 37);
    lit("write_busy_cycles", busy_cnt[0], 36);
    lit("write_addr_pulse_len", wla[0], 10);
    lit("write_data_pulse_len", wld[0], 10);
    lit("write_read_low", rlow[0], 0);
    lit("ones_done_cycle", done_cyc[1], k + 9);
    lit("ones_busy_cycles", busy_cnt[1], 8);

    // Read 0x22, chip returns 0x59
    $display("txn: read addr=22 bus=59");
    bus_val = 8'h59;
    clear_ctrs();
    start(1'b0, 8'h22, 8'h00, k);
    wait_done(0, "read_done");
    lit("read_rdata", rdata_o[0], 8'h59);
    lit("ones_read_rdata", rdata_o[1], 8'h59);
    lit("read_data_phase_oe", data_oe[0], 0);
    lit("read_read_low", rlow[0], 10);

    // Write after read keeps rdata
    $display("txn: write addr=10 wdata=77");
    bus_val = 8'hC3;
    start(1'b1, 8'h10, 8'h77, k);
    wait_done(0, "write2_done");
    lit("write2_rdata_kept", rdata_o[0], 8'h59);

    // req held through busy with changing addr
    $display("txn: read addr=30 with req held, addr changed to 31");
    bus_val = 8'h3C;
    clear_ctrs();
    @(negedge clk);
    wr = 1'b0; addr = 8'h30; req = 1'b1;
    k = cyc;
    @(negedge clk);
    addr = 8'h31;
    wait_done(0, "held_done");
    lit("held_done_count", done_cnt[0], 1);
    lit("held_done_cycle", done_cyc[0], k + 37);
    lit("held_rdata", rdata_o[0], 8'h3C);
    @(negedge clk);
    req = 1'b0;
    lit("held_reaccept_busy", busy_o[0], 1);
    wait_done(0, "held2_done");
    lit("held2_done_cycle", done_cyc[0], k + 74);

    // Reset during data-phase Read pulse
    $display("txn: read addr=22 interrupted by reset in D_PULSE");
    bus_val = 8'h59;
    start(1'b0, 8'h22, 8'h00, k);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (rd_o[0] === 1'b0) seen = 1;
    end
    lit("reset_wait_read_low", seen, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lit("abort_read_high", rd_o[0], 1);
    lit("abort_cs_high", cs_o[0], 1);
    lit("abort_oe", oe_o[0], 0);
    lit("abort_busy", busy_o[0], 0);
    lit("abort_rdata", rdata_o[0], 0);
    clear_ctrs();
    repeat (45) @(negedge clk);
    lit("abort_no_done", done_cnt[0], 0);
    lit("abort_no_busy", busy_cnt[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rtc_bus_ctrl.md
# rtc_bus_ctrl

Transaction engine between the RTC read/write state machines and the external RTC chip's multiplexed address/data bus. Accepts one read or write request at a time (register address plus data), generates the ChipSelect/Read/Write/AoD strobe sequence with programmable cycle timing, and returns read data with a one-cycle completion pulse. Sits directly downstream of the RTC state-machine block; the top level owns the bidirectional pad (ad_out/ad_oe/ad_in).

## Interface
- SETUP_CYC, 2, cycles of CS low before a strobe falls (address/data valid); ≥1
- PULSE_CYC, 10, cycles of Read/Write strobe low; ≥1; must cover chip access time
- HOLD_CYC, 2, cycles of CS low and bus driven after a strobe rises; ≥1
- GAP_CYC, 4, cycles of CS high between address and data phases and after the data phase; ≥1
- clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- req  in  1  start request; sampled only in IDLE
- wr  in  1  1 = write, 0 = read; captured with req
- addr  in  8  RTC register address; captured with req
- wdata  in  8  write data; captured with req
- busy  out  1  high from the cycle after acceptance through the last GAP cycle
- done  out  1  one-cycle pulse on completion
- rdata  out  8  last read value; holds until next read completes
- ChipSelect  out  1  chip select, active low
- Read  out  1  read strobe, active low
- Write  out  1  write strobe, active low
- AoD  out  1  0 = address phase, 1 = data phase
- ad_out  out  8  bus drive value
- ad_oe  out  1  bus output enable to pad
- ad_in  in  8  bus value from pad

## Operation
- States: IDLE, A_SETUP, A_PULSE, A_HOLD, A_GAP, D_SETUP, D_PULSE, D_HOLD, D_GAP; each non-IDLE state lasts exactly its parameter count, then advances in listed order; D_GAP → IDLE.
- IDLE: ChipSelect=Read=Write=1, AoD=1, ad_oe=0, busy=0. req=1 → capture wr/addr/wdata, go A_SETUP.
- A_SETUP: ChipSelect=0, AoD=0, ad_oe=1, ad_out=addr. A_PULSE: same plus Write=0 (address latched by Write strobe for both read and write). A_HOLD: Write=1, rest unchanged.
- A_GAP: ChipSelect=1, ad_oe=0, AoD=1.
- D_SETUP: ChipSelect=0, AoD=1, ad_oe=wr, ad_out=wdata. D_PULSE: Write=0 if wr, else Read=0. D_HOLD: strobes high, ChipSelect=0, ad_oe=wr.
- Read capture: rdata<=ad_in on the last D_PULSE cycle (edge where Read rises); writes never change rdata.
- D_GAP: as A_GAP. done=1 in the first IDLE cycle after D_GAP.
- req while busy ignored, not queued; inputs other than at acceptance ignored.
- Reset: next cycle state=IDLE, ChipSelect=Read=Write=1, AoD=1, ad_oe=0, ad_out=0, busy=0, done=0, rdata=0; an interrupted transaction produces no done.

## Timing
- All bus outputs, busy, done, rdata driven from flops; no combinational path from inputs to outputs (glitch-free strobes).
- req sampled at edge k → A_SETUP from cycle k+1; done high in cycle k+2·(SETUP+PULSE+HOLD+GAP)+1; defaults: 36 busy cycles, done at k+37.
- Cycle with done=1 is IDLE: req that cycle is accepted → back-to-back throughput one transaction per 2·(S+P+H+G)+1 cycles.
- ad_out/ad_oe change only on ChipSelect-high cycles or coincident with CS falling, never while a strobe is low.
- Phase counter width = clog2(max parameter)+1; loads param−1 on state entry, advances at 0.

## Structure
- Package rtc_bus_pkg: state enum, default timing constants, strobe-inactive constant (3'b111 for CS/RD/WR).
- Sub-module rtc_phase_timer: loadable down-counter with load value and expire flag; one instance shared by all phases.

## Test plan
- Write addr=0x21, wdata=0x45: one Write pulse with AoD=0 bus=0x21 (10 cycles), then one with AoD=1 bus=0x45; Read never low; done at k+37.
- Read addr=0x22, bus model returns 0x59 while Read low: rdata=0x59 with done; ad_oe=0 throughout data phase.
- req held high during busy with different addr: ignored; only one transaction; new accepted on done cycle.
- Reset asserted in D_PULSE of a read: next cycle all strobes high, ad_oe=0, busy=0, rdata=0, no done pulse.
- All params=1: transaction busy 8 cycles, done at k+9, strobe ordering preserved.
- Write after read: rdata keeps read value (0x59) after write done.
